mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode, IR[31:26].
REQ-005 funct  input  6  R-type function field, IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pc_en  output  1  PC load enable = pc_write | (branch & zero).
REQ-008 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  2-input datapath mux selects and write enables.
REQ-009 alu_src_b, pc_src  output  2 each  4-input mux selects.
REQ-010 alu_control  output  3  ALU operation.
REQ-011 state  output  4  current state, for debug.

Function
REQ-012 The block SHALL be a Moore FSM that drives every select and enable in the multicycle datapath.
REQ-013 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-014 Transitions SHALL be:
- FETCH->DECODE.
- From DECODE, by op: lw 100011 or sw 101011 -> MEMADR; 000000 -> RTEX; beq 000100 -> BEQEX; addi 001000 -> ADDIEX; j 000010 -> JEX; any other op -> FETCH (executed as a nop).
- MEMADR -> MEMRD if op is lw, else MEMWR.
- MEMRD->MEMWB; RTEX->RTWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX -> FETCH.
- Encodings 12-15 -> FETCH.
REQ-015 Outputs per state SHALL be as below; any signal not listed is 0.
- FETCH: alu_src_b=01, aluop=00, ir_write=1, pc_write=1.
- DECODE: alu_src_b=11, aluop=00.
- MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: mem_to_reg=1, reg_write=1.
- MEMWR: iord=1, mem_write=1.
- RTEX: alu_src_a=1, aluop=10.
- RTWB: reg_dst=1, reg_write=1.
- BEQEX: alu_src_a=1, aluop=01, pc_src=01, branch=1.
- ADDIWB: reg_write=1.
- JEX: pc_src=10, pc_write=1.
REQ-016 alu_control SHALL be decoded combinationally:
- aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
- aluop 10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
- aluop 11 -> 010.
REQ-017 Instruction latency in cycles from entering FETCH to returning to FETCH SHALL be: lw 5; sw, R-type and addi 4; beq and j 3; unknown op 2.
REQ-018 op and funct SHALL be sampled only in DECODE and MEMADR; changes to them in other states SHALL have no effect.
REQ-019 pc_en in BEQEX SHALL follow zero combinationally within the same cycle.

Reset
REQ-020 When reset is sampled high at a clock edge, state SHALL become FETCH, from any state including mid-instruction.
REQ-021 While reset is high, pc_en, ir_write, mem_write and reg_write SHALL be forced to 0, and all other outputs SHALL take their FETCH values.

Configuration
REQ-022 Macro MC_ADDI_EN:
- Defined: addi follows DECODE->ADDIEX->ADDIWB->FETCH.
- Undefined: op 001000 is treated as unknown (DECODE->FETCH), ADDIEX and ADDIWB are unreachable, and those encodings -> FETCH.

Structure
REQ-023 State encodings, opcode and funct constants, and aluop codes SHALL reside in a shared include header with an include guard, reused by the datapath and the testbenches.
REQ-024 The ALU-control decode SHALL be a separate sub-module, alu_decoder (inputs aluop, funct; output alu_control), instantiated once.

Verification
REQ-025 Reset held 2 cycles from an arbitrary state, then released -> state=0, write enables 0 during reset, first post-reset cycle ir_write=1 and pc_en=1.
REQ-026 op=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-027 op=000000, funct=101010 -> states 0,1,6,7,0; alu_control=111 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-028 op=000100 with zero=1, then repeated with zero=0 -> pc_src=01 in state 8; pc_en=1 then 0 respectively.
REQ-029 op=001000 -> states 0,1,9,10,0 with MC_ADDI_EN defined; states 0,1,0 with it undefined. op=111111 -> states 0,1,0.
REQ-030 reset asserted during MEMWR -> mem_write=0 in that cycle and state=0 on the next edge.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multicycle control FSM: state encodings, opcodes, funct codes, ALU codes.
// Optional addi support is selected with the MC_ADDI_EN macro.
`ifndef MC_CONTROL_FSM_PKG_SV
`define MC_CONTROL_FSM_PKG_SV
package mc_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JEX    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] aluop;
   } ctrl_t;

   // Moore output table: every control value is a pure function of the state.
   function automatic ctrl_t state_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_b = 2'b01;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: c.iord = 1'b1;
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_RTEX: begin
            c.alu_src_a = 1'b1;
            c.aluop     = ALUOP_FUNCT;
         end
         S_RTWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BEQEX: begin
            c.alu_src_a = 1'b1;
            c.aluop     = ALUOP_SUB;
            c.pc_src    = 2'b01;
            c.branch    = 1'b1;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JEX: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage
`endif

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mc_control_fsm_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en;
   logic       iord;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, state
   );

   modport slave (
      output op, funct, zero,
      input  pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, state
   );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU control decode: maps the FSM's aluop and the R-type funct field to an ALU operation.
module alu_decoder
   import mc_control_fsm_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALUC_ADD;
      case (aluop)
         ALUOP_ADD:  alu_control = ALUC_ADD;
         ALUOP_SUB:  alu_control = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALUC_ADD;
               FN_SUB:  alu_control = ALUC_SUB;
               FN_AND:  alu_control = ALUC_AND;
               FN_OR:   alu_control = ALUC_OR;
               FN_SLT:  alu_control = ALUC_SLT;
               default: alu_control = ALUC_ADD;
            endcase
         end
         ALUOP_RSVD: alu_control = ALUC_ADD;
         default:    alu_control = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath; outputs are registered alongside the state.
// Define MC_ADDI_EN to add the addi path (ADDIEX -> ADDIWB); otherwise addi executes as a nop.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   mc_control_fsm_if.master  bus
);

   state_t     state_q, state_d;
   ctrl_t      ctrl_q, ctrl_d, ctrl_out;
   logic [5:0] funct_q, funct_d;
   logic [2:0] alu_control;

   // funct is captured in DECODE so later funct changes cannot disturb RTEX.
   always_comb begin
      state_d = S_FETCH;
      funct_d = funct_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            funct_d = bus.funct;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEX;
               OP_BEQ:       state_d = S_BEQEX;
`ifdef MC_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               OP_J:         state_d = S_JEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_RTEX:   state_d = S_RTWB;
`ifdef MC_ADDI_EN
         S_ADDIEX: state_d = S_ADDIWB;
`endif
         default:  state_d = S_FETCH;
      endcase
      ctrl_d = state_ctrl(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH);
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         funct_q <= funct_d;
      end
   end

   // Reset overrides the registered outputs immediately, with every write enable held off.
   always_comb begin
      ctrl_out = ctrl_q;
      if (reset) begin
         ctrl_out           = state_ctrl(S_FETCH);
         ctrl_out.pc_write  = 1'b0;
         ctrl_out.ir_write  = 1'b0;
         ctrl_out.mem_write = 1'b0;
         ctrl_out.reg_write = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .aluop       (ctrl_out.aluop),
      .funct       (funct_q),
      .alu_control (alu_control)
   );

   assign bus.pc_en       = ctrl_out.pc_write | (ctrl_out.branch & bus.zero);
   assign bus.iord        = ctrl_out.iord;
   assign bus.ir_write    = ctrl_out.ir_write;
   assign bus.mem_write   = ctrl_out.mem_write;
   assign bus.reg_write   = ctrl_out.reg_write;
   assign bus.reg_dst     = ctrl_out.reg_dst;
   assign bus.mem_to_reg  = ctrl_out.mem_to_reg;
   assign bus.alu_src_a   = ctrl_out.alu_src_a;
   assign bus.alu_src_b   = ctrl_out.alu_src_b;
   assign bus.pc_src      = ctrl_out.pc_src;
   assign bus.alu_control = alu_control;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a per-instruction state-path model checked every negedge.
// Honours MC_ADDI_EN the same way as the design.
module tb_mc_control_fsm;
   import mc_control_fsm_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;

   mc_control_fsm_if bus ();

   mc_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
   } obs_t;

   typedef struct {
      int         st;
      logic [5:0] fn;
   } step_t;

   step_t exp_q[$];
   int    compared   = 0;
   int    mismatched = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, actual, required, $time);
      end
   endtask

   function automatic obs_t observed();
      obs_t o;
      o.pc_en       = bus.pc_en;
      o.iord        = bus.iord;
      o.ir_write    = bus.ir_write;
      o.mem_write   = bus.mem_write;
      o.reg_write   = bus.reg_write;
      o.reg_dst     = bus.reg_dst;
      o.mem_to_reg  = bus.mem_to_reg;
      o.alu_src_a   = bus.alu_src_a;
      o.alu_src_b   = bus.alu_src_b;
      o.pc_src      = bus.pc_src;
      o.alu_control = bus.alu_control;
      return o;
   endfunction

   // R-type ALU operation straight from the funct table.
   function automatic logic [2:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic obs_t expected_obs(input int s, input logic z, input logic [5:0] f);
      obs_t o;
      o = '0;
      o.alu_control = 3'b010;
      case (s)
         0:  begin o.pc_en = 1'b1; o.ir_write = 1'b1; o.alu_src_b = 2'b01; end
         1:  o.alu_src_b = 2'b11;
         2, 9: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         3:  o.iord = 1'b1;
         4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
         5:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
         6:  begin o.alu_src_a = 1'b1; o.alu_control = rtype_alu(f); end
         7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
         8:  begin o.alu_src_a = 1'b1; o.pc_src = 2'b01; o.pc_en = z; o.alu_control = 3'b110; end
         10: o.reg_write = 1'b1;
         11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.alu_src_b   = 2'b01;
      o.alu_control = 3'b010;
      return o;
   endfunction

   // Queue the states an instruction walks through, starting with its FETCH.
   task automatic pushPath(input logic [5:0] op, input logic [5:0] fn, output int len);
      int    states[$];
      step_t s;
      case (op)
         6'b100011: states = '{0, 1, 2, 3, 4};
         6'b101011: states = '{0, 1, 2, 5};
         6'b000000: states = '{0, 1, 6, 7};
         6'b000100: states = '{0, 1, 8};
         6'b000010: states = '{0, 1, 11};
`ifdef MC_ADDI_EN
         6'b001000: states = '{0, 1, 9, 10};
`endif
         default:   states = '{0, 1};
      endcase
      foreach (states[i]) begin
         s.st = states[i];
         s.fn = fn;
         exp_q.push_back(s);
      end
      len = states.size();
   endtask

   always @(negedge clk) begin
      step_t s;
      if (reset) begin
         checkOutput("outputs_during_reset", 32'(observed()), 32'(reset_obs()));
      end else if (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         checkOutput($sformatf("state_expect_%0d", s.st), 32'(bus.state), 32'(s.st));
         checkOutput($sformatf("outputs_in_state_%0d", s.st), 32'(observed()),
                     32'(expected_obs(s.st, bus.zero, s.fn)));
      end
   end

   // Run one instruction from FETCH back to FETCH; optionally disturb op/funct once in the execute state.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit scramble);
      int len;
      bus.op    = op;
      bus.funct = fn;
      bus.zero  = z;
      pushPath(op, fn, len);
      for (int i = 1; i <= len; i++) begin
         @(posedge clk);
         #1;
         if (scramble && i == 2) begin
            bus.op    = OP_J;
            bus.funct = FN_AND;
         end
      end
   endtask

   initial begin
      int    len;
      step_t tail;

      bus.op    = 6'b110011;
      bus.funct = 6'b000000;
      bus.zero  = 1'b0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("state_after_initial_reset", 32'(bus.state), 32'd0);
      reset = 1'b0;

      applyStimulus(OP_LW,    6'b000000, 1'b0, 1'b0);
      applyStimulus(OP_SW,    6'b000000, 1'b0, 1'b0);
      applyStimulus(OP_RTYPE, FN_SLT,    1'b0, 1'b1);
      applyStimulus(OP_RTYPE, FN_ADD,    1'b0, 1'b0);
      applyStimulus(OP_RTYPE, FN_SUB,    1'b0, 1'b0);
      applyStimulus(OP_RTYPE, FN_AND,    1'b0, 1'b0);
      applyStimulus(OP_RTYPE, FN_OR,     1'b0, 1'b0);
      applyStimulus(OP_RTYPE, 6'b000111, 1'b0, 1'b0);
      applyStimulus(OP_BEQ,   6'b000000, 1'b1, 1'b0);

      // beq with zero low, then zero raised mid-BEQEX: pc_en must follow at once.
      bus.op   = OP_BEQ;
      bus.zero = 1'b0;
      pushPath(OP_BEQ, 6'b000000, len);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("beq_state_literal", 32'(bus.state), 32'd8);
      checkOutput("beq_pc_src_literal", 32'(bus.pc_src), 32'b01);
      @(negedge clk);
      #1;
      bus.zero = 1'b1;
      #1;
      checkOutput("beq_pc_en_follows_zero", 32'(bus.pc_en), 32'd1);
      @(posedge clk);
      #1;
      bus.zero = 1'b0;

      applyStimulus(OP_ADDI,   6'b000000, 1'b0, 1'b0);
      applyStimulus(OP_J,      6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b0);

      // sw interrupted by reset in MEMWR, reset held for two edges.
      bus.op = OP_SW;
      pushPath(OP_SW, 6'b000000, len);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("memwr_state_before_edge", 32'(bus.state), 32'd5);
      checkOutput("memwr_mem_write_blocked", 32'(bus.mem_write), 32'd0);
      checkOutput("reset_pc_en_blocked", 32'(bus.pc_en), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("state_after_reset_edge", 32'(bus.state), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("post_reset_ir_write", 32'(bus.ir_write), 32'd1);
      checkOutput("post_reset_pc_en", 32'(bus.pc_en), 32'd1);

      applyStimulus(OP_LW,     6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b001001, 6'b000000, 1'b0, 1'b0);

      tail.st = 0;
      tail.fn = 6'b000000;
      exp_q.push_back(tail);
      @(negedge clk);
      #1;
      checkOutput("model_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
